// File: rtl/gpio_pkg.sv
// Purpose: shared constants for the GPIO bank: bus width, address fields, register offsets.
// Latency: none; constants and types only.
// Backpressure: none; the IO bus has no stall, so every access completes.
package gpio_pkg;

  localparam int BUS_W      = 16;  // IO bus data width
  localparam int ADDR_W     = 6;   // {port[5:3], reg[2:0]}
  localparam int PORT_SEL_W = 3;
  localparam int REG_SEL_W  = 3;
  localparam int BLANK_W    = 3;   // holds SYNC_STAGES+1 for SYNC_STAGES up to 4

  typedef logic [REG_SEL_W-1:0] reg_sel_t;

  localparam reg_sel_t REG_DATA    = 3'd0;
  localparam reg_sel_t REG_SET     = 3'd1;
  localparam reg_sel_t REG_CLR     = 3'd2;
  localparam reg_sel_t REG_TGL     = 3'd3;
  localparam reg_sel_t REG_DIR     = 3'd4;
  localparam reg_sel_t REG_RISE_EN = 3'd5;
  localparam reg_sel_t REG_FALL_EN = 3'd6;
  localparam reg_sel_t REG_EVENT   = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// Purpose: per-port input synchroniser plus previous-value flop and rise/fall detect.
// Latency: pad change sampled at edge k appears on sync_val after edge k+SYNC_STAGES-1.
// Backpressure: none; free-running every cycle.
// Ports: clk, reset (sync, active-high), blank (forces rise/fall to 0),
//        pin_in (raw pads), sync_val (synchronised level), rise, fall (one-cycle pulses).
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blank,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  always_comb begin
    sync_d[0] = pin_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    // prev keeps following the synchroniser even while blanked, so no
    // stale edge is left pending when blanking ends.
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign rise     = blank ? '0 : (sync_val & ~prev_q);
  assign fall     = blank ? '0 : (~sync_val & prev_q);

endmodule

// File: rtl/gpio_bank.sv
// Purpose: PORTS x WIDTH GPIO bank on the J1 IO bus: out/dir registers, edge capture, level irq.
// Latency: writes land at the sampling edge; read data/valid one cycle after io_rd.
// Backpressure: none; every bus access is accepted in its cycle.
// Ports: clk, reset (sync, active-high); io_wr/io_rd/io_addr/io_wdata bus in;
//        io_rdata/io_rvalid bus out; pin_in pads; pin_out/pin_oe pad drive; irq.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PORTS       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_wr,
  input  logic                   io_rd,
  input  logic [ADDR_W-1:0]      io_addr,
  input  logic [BUS_W-1:0]       io_wdata,
  output logic [BUS_W-1:0]       io_rdata,
  output logic                   io_rvalid,
  input  logic [PORTS*WIDTH-1:0] pin_in,
  output logic [PORTS*WIDTH-1:0] pin_out,
  output logic [PORTS*WIDTH-1:0] pin_oe,
  output logic                   irq
);

  logic [PORT_SEL_W-1:0] port_sel;
  reg_sel_t              reg_sel;
  logic [WIDTH-1:0]      wdata;
  logic                  unused_wdata;

  assign port_sel = io_addr[ADDR_W-1 -: PORT_SEL_W];
  assign reg_sel  = io_addr[REG_SEL_W-1:0];
  assign wdata    = io_wdata[WIDTH-1:0];
  // Bus bits above WIDTH are don't-care for narrow ports.
  assign unused_wdata = ^io_wdata;

  logic [WIDTH-1:0] out_q     [PORTS];
  logic [WIDTH-1:0] out_d     [PORTS];
  logic [WIDTH-1:0] oe_q      [PORTS];
  logic [WIDTH-1:0] oe_d      [PORTS];
  logic [WIDTH-1:0] rise_en_q [PORTS];
  logic [WIDTH-1:0] rise_en_d [PORTS];
  logic [WIDTH-1:0] fall_en_q [PORTS];
  logic [WIDTH-1:0] fall_en_d [PORTS];
  logic [WIDTH-1:0] event_q   [PORTS];
  logic [WIDTH-1:0] event_d   [PORTS];

  logic [WIDTH-1:0] sync_val  [PORTS];
  logic [WIDTH-1:0] rise      [PORTS];
  logic [WIDTH-1:0] fall      [PORTS];

  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic               blank;
  logic [BUS_W-1:0]   rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  // Edge capture is held off for SYNC_STAGES+1 cycles after reset so pads
  // that were already high do not look like rising edges.
  assign blank       = (blank_cnt_q != '0);
  assign blank_cnt_d = blank ? (blank_cnt_q - BLANK_W'(1)) : blank_cnt_q;

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    gpio_sync_edge #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk     (clk),
      .reset   (reset),
      .blank   (blank),
      .pin_in  (pin_in[p*WIDTH +: WIDTH]),
      .sync_val(sync_val[p]),
      .rise    (rise[p]),
      .fall    (fall[p])
    );

    assign pin_out[p*WIDTH +: WIDTH] = out_q[p];
    assign pin_oe[p*WIDTH +: WIDTH]  = oe_q[p];
  end

  // Register file update. Port indices >= PORTS never match a loop index,
  // so writes to them fall through untouched.
  always_comb begin
    logic [WIDTH-1:0] capture;
    capture = '0;
    for (int p = 0; p < PORTS; p++) begin
      capture      = (rise[p] & rise_en_q[p]) | (fall[p] & fall_en_q[p]);
      out_d[p]     = out_q[p];
      oe_d[p]      = oe_q[p];
      rise_en_d[p] = rise_en_q[p];
      fall_en_d[p] = fall_en_q[p];
      event_d[p]   = event_q[p] | capture;
      if (io_wr && (port_sel == PORT_SEL_W'(p))) begin
        case (reg_sel)
          REG_DATA:    out_d[p]     = wdata;
          REG_SET:     out_d[p]     = out_q[p] | wdata;
          REG_CLR:     out_d[p]     = out_q[p] & ~wdata;
          REG_TGL:     out_d[p]     = out_q[p] ^ wdata;
          REG_DIR:     oe_d[p]      = wdata;
          REG_RISE_EN: rise_en_d[p] = wdata;
          REG_FALL_EN: fall_en_d[p] = wdata;
          // A new capture on the same bit beats the clear.
          REG_EVENT:   event_d[p]   = (event_q[p] & ~wdata) | capture;
          default:     ;
        endcase
      end
    end
  end

  // Read mux works from current register state, so a simultaneous write
  // to the same address is not visible in this read.
  always_comb begin
    logic [BUS_W-1:0] rd_val;
    rd_val = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (port_sel == PORT_SEL_W'(p)) begin
        case (reg_sel)
          REG_DATA:                 rd_val = BUS_W'(sync_val[p]);
          REG_SET, REG_CLR, REG_TGL: rd_val = BUS_W'(out_q[p]);
          REG_DIR:                  rd_val = BUS_W'(oe_q[p]);
          REG_RISE_EN:              rd_val = BUS_W'(rise_en_q[p]);
          REG_FALL_EN:              rd_val = BUS_W'(fall_en_q[p]);
          REG_EVENT:                rd_val = BUS_W'(event_q[p]);
          default:                  rd_val = '0;
        endcase
      end
    end
    rdata_d  = io_rd ? rd_val : rdata_q;
    rvalid_d = io_rd;
  end

  always_comb begin
    irq = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      irq = irq | (|(event_q[p] & (rise_en_q[p] | fall_en_q[p])));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < PORTS; p++) begin
        out_q[p]     <= '0;
        oe_q[p]      <= '0;
        rise_en_q[p] <= '0;
        fall_en_q[p] <= '0;
        event_q[p]   <= '0;
      end
      blank_cnt_q <= BLANK_W'(SYNC_STAGES + 1);
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        out_q[p]     <= out_d[p];
        oe_q[p]      <= oe_d[p];
        rise_en_q[p] <= rise_en_d[p];
        fall_en_q[p] <= fall_en_d[p];
        event_q[p]   <= event_d[p];
      end
      blank_cnt_q <= blank_cnt_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign io_rdata  = rdata_q;
  assign io_rvalid = rvalid_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Purpose: self-checking bench for gpio_bank: directed vectors, corner sequences, random vs model.
// Latency: checks are taken 1 time unit after each rising clock edge.
// Backpressure: none; the bench drives one bus access per cycle.
module tb_gpio_bank;

  localparam int W  = 8;
  localparam int P  = 3;
  localparam int S  = 2;
  localparam int PW = P * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_wr, io_rd;
  logic [5:0]    io_addr;
  logic [15:0]   io_wdata;
  logic [15:0]   io_rdata;
  logic          io_rvalid;
  logic [PW-1:0] pin_in, pin_out, pin_oe;
  logic          irq;
  logic          loop_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_bank #(.WIDTH(W), .PORTS(P), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_rvalid(io_rvalid),
    .pin_in   (pin_in),
    .pin_out  (pin_out),
    .pin_oe   (pin_oe),
    .irq      (irq)
  );

  // Reference model: architectural registers plus a history of pad samples.
  // hist[0] is the sample taken at the most recent edge; the synchronised
  // level lags the pad by S-1 samples and edges are judged one sample later.
  logic [W-1:0]  m_out [P];
  logic [W-1:0]  m_oe  [P];
  logic [W-1:0]  m_ren [P];
  logic [W-1:0]  m_fen [P];
  logic [W-1:0]  m_ev  [P];
  logic [15:0]   m_rdata;
  logic          m_rvalid;
  logic [PW-1:0] hist [S+1];
  int            m_edges;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [5:0] a);
    int p;
    logic [W-1:0] v;
    p = int'(a[5:3]);
    v = '0;
    if (p < P) begin
      case (a[2:0])
        3'd0:             v = hist[S-1][p*W +: W];
        3'd1, 3'd2, 3'd3: v = m_out[p];
        3'd4:             v = m_oe[p];
        3'd5:             v = m_ren[p];
        3'd6:             v = m_fen[p];
        default:          v = m_ev[p];
      endcase
    end
    return 16'(v);
  endfunction

  task automatic model_update(input logic r, input logic wr, input logic rd,
                              input logic [5:0] a, input logic [15:0] d, input logic [PW-1:0] pin);
    logic [W-1:0] newer, older, cap, wd;
    int ap;
    if (r) begin
      for (int p = 0; p < P; p++) begin
        m_out[p] = '0; m_oe[p] = '0; m_ren[p] = '0; m_fen[p] = '0; m_ev[p] = '0;
      end
      for (int i = 0; i <= S; i++) hist[i] = '0;
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_edges  = 0;
    end else begin
      m_edges++;
      m_rvalid = rd;
      if (rd) m_rdata = model_read(a);
      ap = int'(a[5:3]);
      wd = d[W-1:0];
      for (int p = 0; p < P; p++) begin
        newer = hist[S-1][p*W +: W];
        older = hist[S][p*W +: W];
        cap = (m_edges > S + 1) ? ((newer & ~older & m_ren[p]) | (~newer & older & m_fen[p])) : '0;
        if (wr && ap == p) begin
          case (a[2:0])
            3'd0: m_out[p] = wd;
            3'd1: m_out[p] = m_out[p] | wd;
            3'd2: m_out[p] = m_out[p] & ~wd;
            3'd3: m_out[p] = m_out[p] ^ wd;
            3'd4: m_oe[p]  = wd;
            3'd5: m_ren[p] = wd;
            3'd6: m_fen[p] = wd;
            default: m_ev[p] = m_ev[p] & ~wd;
          endcase
        end
        m_ev[p] = m_ev[p] | cap;
      end
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pin;
    end
  endtask

  task automatic tick();
    logic r, wr, rd;
    logic [5:0] a;
    logic [15:0] d;
    logic [PW-1:0] pin, e_out, e_oe;
    logic e_irq;
    r = reset; wr = io_wr; rd = io_rd; a = io_addr; d = io_wdata; pin = pin_in;
    @(posedge clk);
    model_update(r, wr, rd, a, d, pin);
    #1;
    e_irq = 1'b0;
    for (int p = 0; p < P; p++) begin
      e_out[p*W +: W] = m_out[p];
      e_oe[p*W +: W]  = m_oe[p];
      e_irq = e_irq | (|(m_ev[p] & (m_ren[p] | m_fen[p])));
    end
    chk("model_pin_out", pin_out, e_out);
    chk("model_pin_oe", pin_oe, e_oe);
    chk("model_irq", irq, e_irq);
    chk("model_rvalid", io_rvalid, m_rvalid);
    chk("model_rdata", io_rdata, m_rdata);
    if (loop_en) pin_in[W-1:0] = pin_out[W-1:0] & pin_oe[W-1:0];
  endtask

  task automatic cyc(input logic wr, input logic rd, input logic [5:0] a, input logic [15:0] d);
    io_wr = wr; io_rd = rd; io_addr = a; io_wdata = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 6'd0, 16'h0);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [23:0] exp_out;
    logic [23:0] exp_oe;
    logic        exp_rv;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Port 1 register ops, readback, bus-above-WIDTH masking, out-of-range ports.
    tbl[0]  = '{1'b1, 1'b0, 6'd8,  16'h00A5, 24'h00A500, 24'h000000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 6'd9,  16'h000F, 24'h00AF00, 24'h000000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 6'd10, 16'h0081, 24'h002E00, 24'h000000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 6'd11, 16'h00FF, 24'h00D100, 24'h000000, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 6'd9,  16'h0000, 24'h00D100, 24'h000000, 1'b1, 16'h00D1};
    tbl[5]  = '{1'b0, 1'b0, 6'd0,  16'h0000, 24'h00D100, 24'h000000, 1'b0, 16'h00D1};
    tbl[6]  = '{1'b1, 1'b0, 6'd8,  16'hFF5A, 24'h005A00, 24'h000000, 1'b0, 16'h00D1};
    tbl[7]  = '{1'b1, 1'b1, 6'd9,  16'h0001, 24'h005B00, 24'h000000, 1'b1, 16'h005A};
    tbl[8]  = '{1'b1, 1'b0, 6'd12, 16'h003C, 24'h005B00, 24'h003C00, 1'b0, 16'h005A};
    tbl[9]  = '{1'b0, 1'b1, 6'd12, 16'h0000, 24'h005B00, 24'h003C00, 1'b1, 16'h003C};
    tbl[10] = '{1'b1, 1'b0, 6'd40, 16'hFFFF, 24'h005B00, 24'h003C00, 1'b0, 16'h003C};
    tbl[11] = '{1'b0, 1'b1, 6'd40, 16'h0000, 24'h005B00, 24'h003C00, 1'b1, 16'h0000};
    tbl[12] = '{1'b1, 1'b0, 6'd63, 16'hFFFF, 24'h005B00, 24'h003C00, 1'b0, 16'h0000};
    tbl[13] = '{1'b1, 1'b0, 6'd12, 16'h0000, 24'h005B00, 24'h000000, 1'b0, 16'h0000};
    tbl[14] = '{1'b1, 1'b0, 6'd8,  16'h0000, 24'h000000, 24'h000000, 1'b0, 16'h0000};

    // Reset with every pad high, then enable rising capture during blanking.
    loop_en = 1'b0;
    reset = 1'b1; io_wr = 1'b0; io_rd = 1'b0; io_addr = '0; io_wdata = '0; pin_in = '1;
    repeat (3) tick();
    chk("reset_pin_oe", pin_oe, 24'h0);
    chk("reset_pin_out", pin_out, 24'h0);
    chk("reset_irq", irq, 1'b0);
    chk("reset_rvalid", io_rvalid, 1'b0);
    chk("reset_rdata", io_rdata, 16'h0);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 6'd5,  16'h00FF);
    cyc(1'b1, 1'b0, 6'd13, 16'h00FF);
    cyc(1'b1, 1'b0, 6'd21, 16'h00FF);
    idle(3);
    cyc(1'b0, 1'b1, 6'd7, 16'h0);
    chk("blank_event0", io_rdata, 16'h0);
    chk("blank_rvalid", io_rvalid, 1'b1);
    chk("blank_irq", irq, 1'b0);
    cyc(1'b0, 1'b1, 6'd15, 16'h0);
    chk("blank_event1", io_rdata, 16'h0);

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d_out", i), pin_out, tbl[i].exp_out);
      chk($sformatf("tbl%0d_oe", i), pin_oe, tbl[i].exp_oe);
      chk($sformatf("tbl%0d_rvalid", i), io_rvalid, tbl[i].exp_rv);
      chk($sformatf("tbl%0d_rdata", i), io_rdata, tbl[i].exp_rd);
    end

    // Rising edge on port 0 bit 0: EVENT and irq exactly S edges later.
    cyc(1'b1, 1'b0, 6'd5,  16'h0001);
    cyc(1'b1, 1'b0, 6'd13, 16'h0000);
    cyc(1'b1, 1'b0, 6'd21, 16'h0000);
    pin_in = '0;
    idle(4);
    chk("rise_irq_quiet", irq, 1'b0);
    pin_in = 24'h000001;
    idle(1);
    chk("rise_irq_k", irq, 1'b0);
    idle(1);
    chk("rise_irq_k1", irq, 1'b0);
    idle(1);
    chk("rise_irq_k2", irq, 1'b1);
    cyc(1'b0, 1'b1, 6'd7, 16'h0);
    chk("rise_event0", io_rdata, 16'h0001);
    cyc(1'b1, 1'b0, 6'd7, 16'h0001);
    chk("rise_w1c_irq", irq, 1'b0);

    // Fall on port 2 bit 7 coinciding with a W1C of that bit: the set wins.
    pin_in = 24'h800001;
    idle(4);
    cyc(1'b1, 1'b0, 6'd22, 16'h0080);
    pin_in = 24'h000001;
    idle(2);
    chk("fall_irq_early", irq, 1'b0);
    cyc(1'b1, 1'b0, 6'd23, 16'h0080);
    chk("fall_set_wins_irq", irq, 1'b1);
    cyc(1'b0, 1'b1, 6'd23, 16'h0);
    chk("fall_event2", io_rdata, 16'h0080);
    cyc(1'b1, 1'b0, 6'd22, 16'h0000);
    chk("fall_irq_disabled", irq, 1'b0);
    cyc(1'b0, 1'b1, 6'd23, 16'h0);
    chk("fall_event2_kept", io_rdata, 16'h0080);
    cyc(1'b1, 1'b0, 6'd23, 16'h0080);
    cyc(1'b1, 1'b0, 6'd22, 16'h0080);
    chk("fall_irq_cleared", irq, 1'b0);

    // Loopback on port 0: driven bits reappear on DATA after S+1 cycles.
    loop_en = 1'b1;
    cyc(1'b1, 1'b0, 6'd4, 16'h00F0);
    cyc(1'b1, 1'b0, 6'd0, 16'h0030);
    chk("loop_pin_out", pin_out[7:0], 8'h30);
    idle(S);
    cyc(1'b0, 1'b1, 6'd0, 16'h0);
    chk("loop_data_read", io_rdata, 16'h0030);
    chk("loop_data_rvalid", io_rvalid, 1'b1);
    reset = 1'b1;
    cyc(1'b0, 1'b1, 6'd0, 16'h0);
    chk("reset_abort_rvalid", io_rvalid, 1'b0);
    chk("reset_abort_rdata", io_rdata, 16'h0);
    loop_en = 1'b0;
    idle(1);
    reset = 1'b0;

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      reset    = ($urandom_range(0, 299) == 0);
      io_wr    = ($urandom_range(0, 2) == 0);
      io_rd    = ($urandom_range(0, 2) == 0);
      io_addr  = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      io_wdata = 16'($urandom);
      if ($urandom_range(0, 3) == 0) pin_in = PW'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
